clic_irq_arbiter: RTL



---
 rtl/clic_arb_pkg.sv | 21 ++
 rtl/clic_arb_chunk_max.sv | 32 +++
 rtl/clic_irq_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clic_arb_pkg.sv
// Shared types and default sizing for the CLIC interrupt arbiter.
// cand_t field widths follow the default NumSrc/CtlBits below.
package clic_arb_pkg;

  localparam int unsigned NumSrc  = 256;
  localparam int unsigned CtlBits = 8;
  localparam int unsigned IdW     = $clog2(NumSrc);

  typedef enum logic [1:0] {
    SCAN,
    PRESENT,
    CLAIM
  } arb_state_e;

  typedef struct packed {
    logic               valid;
    logic [IdW-1:0]     id;
    logic [CtlBits-1:0] lvl;
  } cand_t;

endpackage

// File: rtl/clic_arb_chunk_max.sv
// Combinational reduction of one chunk of interrupt sources to a single candidate.
// Winner is the eligible source with the highest level; ties go to the higher id.
module clic_arb_chunk_max
  import clic_arb_pkg::*;
#(
  parameter int unsigned SrcPerCycle = 16
) (
  input  logic [SrcPerCycle-1:0]         ip_i,
  input  logic [SrcPerCycle-1:0]         ie_i,
  input  logic [SrcPerCycle*CtlBits-1:0] ctl_i,
  input  logic [CtlBits-1:0]             thresh_i,
  input  logic [IdW-1:0]                 base_i,
  output cand_t                          win_o
);

  logic [CtlBits-1:0] lvl;

  // Ascending walk with >= lets a later (higher) id take an equal level.
  always_comb begin
    win_o = '0;
    lvl   = '0;
    for (int i = 0; i < SrcPerCycle; i++) begin
      lvl = ctl_i[i*CtlBits +: CtlBits];
      if (ip_i[i] && ie_i[i] && (lvl > thresh_i) && (!win_o.valid || lvl >= win_o.lvl)) begin
        win_o.valid = 1'b1;
        win_o.id    = base_i + IdW'(i);
        win_o.lvl   = lvl;
      end
    end
  end

endmodule

// File: rtl/clic_irq_arbiter.sv
// Sequential CLIC priority arbiter: sweeps SrcPerCycle sources per cycle and presents the winner.
// Define CLIC_ARB_PREEMPT_EN to keep sweeping while presenting and replace on a strictly higher level.
module clic_irq_arbiter #(
  parameter int unsigned NumSrc      = clic_arb_pkg::NumSrc,
  parameter int unsigned CtlBits     = clic_arb_pkg::CtlBits,
  parameter int unsigned SrcPerCycle = 16,
  localparam int unsigned NumChunks  = NumSrc / SrcPerCycle,
  localparam int unsigned IdW        = $clog2(NumSrc),
  localparam int unsigned ChunkW     = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumSrc-1:0]         ip_i,
  input  logic [NumSrc-1:0]         ie_i,
  input  logic [NumSrc*CtlBits-1:0] ctl_i,
  input  logic [CtlBits-1:0]        thresh_i,
  output logic                      irq_valid_o,
  input  logic                      irq_ready_i,
  output logic [IdW-1:0]            irq_id_o,
  output logic [CtlBits-1:0]        irq_level_o,
  output logic                      claim_o,
  output logic [IdW-1:0]            claim_id_o
);
  import clic_arb_pkg::*;

  arb_state_e          state_q, state_d;
  logic [ChunkW-1:0]   chunk_q, chunk_d;
  cand_t               best_q, best_d;
  logic                irq_valid_q, irq_valid_d;
  logic [IdW-1:0]      irq_id_q, irq_id_d;
  logic [CtlBits-1:0]  irq_level_q, irq_level_d;
  logic                claim_q, claim_d;
  logic [IdW-1:0]      claim_id_q, claim_id_d;

  logic [SrcPerCycle-1:0]         ip_chunk, ie_chunk;
  logic [SrcPerCycle*CtlBits-1:0] ctl_chunk;
  cand_t                          chunk_win, merged;
  logic                           last_chunk, pres_elig, handshake;
  logic [CtlBits-1:0]             pres_lvl;

  assign ip_chunk  = ip_i[int'(chunk_q)*SrcPerCycle +: SrcPerCycle];
  assign ie_chunk  = ie_i[int'(chunk_q)*SrcPerCycle +: SrcPerCycle];
  assign ctl_chunk = ctl_i[int'(chunk_q)*SrcPerCycle*CtlBits +: SrcPerCycle*CtlBits];

  clic_arb_chunk_max #(
    .SrcPerCycle (SrcPerCycle)
  ) u_chunk_max (
    .ip_i     (ip_chunk),
    .ie_i     (ie_chunk),
    .ctl_i    (ctl_chunk),
    .thresh_i (thresh_i),
    .base_i   (IdW'(int'(chunk_q) * SrcPerCycle)),
    .win_o    (chunk_win)
  );

  // Later chunks win ties because they hold higher ids.
  always_comb begin
    merged = best_q;
    if (chunk_win.valid && (!best_q.valid || chunk_win.lvl >= best_q.lvl)) begin
      merged = chunk_win;
    end
  end

  assign last_chunk = (chunk_q == ChunkW'(NumChunks - 1));
  assign pres_lvl   = ctl_i[int'(irq_id_q)*CtlBits +: CtlBits];
  assign pres_elig  = ip_i[irq_id_q] & ie_i[irq_id_q] & (pres_lvl > thresh_i);
  assign handshake  = irq_valid_q & irq_ready_i;

  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    best_d      = best_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    irq_level_d = irq_level_q;
    claim_d     = 1'b0;
    claim_id_d  = claim_id_q;
    unique case (state_q)
      SCAN: begin
        irq_valid_d = 1'b0;
        chunk_d     = last_chunk ? '0 : chunk_q + ChunkW'(1);
        best_d      = merged;
        if (last_chunk) begin
          best_d = '0;
          if (merged.valid) begin
            state_d     = PRESENT;
            irq_id_d    = merged.id;
            irq_level_d = merged.lvl;
          end
        end
      end
      PRESENT: begin
        if (handshake) begin
          state_d     = CLAIM;
          irq_valid_d = 1'b0;
          claim_d     = 1'b1;
          claim_id_d  = irq_id_q;
          chunk_d     = '0;
          best_d      = '0;
        end else if (!pres_elig) begin
          state_d     = SCAN;
          irq_valid_d = 1'b0;
          chunk_d     = '0;
          best_d      = '0;
        end else begin
          irq_valid_d = 1'b1;
`ifdef CLIC_ARB_PREEMPT_EN
          chunk_d = last_chunk ? '0 : chunk_q + ChunkW'(1);
          best_d  = last_chunk ? '0 : merged;
          if (last_chunk && merged.valid && (merged.lvl > irq_level_q)) begin
            irq_id_d    = merged.id;
            irq_level_d = merged.lvl;
          end
`endif
        end
      end
      CLAIM: begin
        state_d     = SCAN;
        irq_valid_d = 1'b0;
        chunk_d     = '0;
        best_d      = '0;
      end
      default: begin
        state_d     = SCAN;
        irq_valid_d = 1'b0;
        chunk_d     = '0;
        best_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN;
      chunk_q     <= '0;
      best_q      <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_level_q <= '0;
      claim_q     <= 1'b0;
      claim_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      best_q      <= best_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_level_q <= irq_level_d;
      claim_q     <= claim_d;
      claim_id_q  <= claim_id_d;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign irq_level_o = irq_level_q;
  assign claim_o     = claim_q;
  assign claim_id_o  = claim_id_q;

endmodule
